acq_seq_ctrl: RTL and testbench

Acquisition sequencer that drives the DDR write-address generator through one capture frame: re-arm, pre-trigger fill, trigger wait, post-trigger fill, readout hand-off. It sits between the front-panel/trigger logic and the write-address generator, owns that generator's reset, `wr_en` and `auto_rd_en` inputs, and observes its `write_stop`. It supports single-shot, normal and auto (timeout-forced) trigger modes.

---
 rtl/acq_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_acq_seq_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_seq_ctrl.sv
// acq_seq_ctrl
// Acquisition sequencer for one capture frame of the DDR write-address
// generator: re-arm, pre-trigger fill, trigger wait, post-trigger fill and
// readout hand-off. It owns the generator's reset, wr_en and auto_rd_en.
//
// State table (acq_state code):
//   IDLE      (0) | parked; generator held in reset, waiting for run rising edge
//   REARM     (1) | generator reset held RST_HOLD cycles; frame settings latched
//   PRETRIG   (2) | writing; counting sync_en strobes up to the pre-trigger length
//   WAIT_TRIG (3) | ring writing; waiting for trig_in edge, force_trig or timeout
//   POSTTRIG  (4) | writing post-trigger samples until write_stop
//   READOUT   (5) | writes stopped; waiting for rd_done from the readout block
//
// Ports:
//   clk, rst            sample-path clock, asynchronous active-low reset
//   run, single         acquisition enable level, single-shot select
//   auto_mode           force a trigger after timeout_len cycles in WAIT_TRIG
//   force_trig, trig_in immediate trigger pulse, synchronous trigger (rising edge)
//   sync_en             sample-valid strobe counted during PRETRIG
//   pretrig_len         pre-trigger length in sync_en strobes
//   timeout_len         auto-trigger timeout in clk cycles
//   write_stop, rd_done post-fill complete, frame consumed
//   addr_gen_rst_n, wr_en, auto_rd_en   address generator controls
//   rd_start, trig_forced               readout hand-off pulse, trigger source flag
//   acq_state, frame_cnt, busy          status

module acq_seq_ctrl #(
    parameter int ADDR_W   = 28,
    parameter int TO_W     = 32,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              single,
    input  logic              auto_mode,
    input  logic              force_trig,
    input  logic              trig_in,
    input  logic              sync_en,
    input  logic [ADDR_W-1:0] pretrig_len,
    input  logic [TO_W-1:0]   timeout_len,
    input  logic              write_stop,
    input  logic              rd_done,
    output logic              addr_gen_rst_n,
    output logic              wr_en,
    output logic              auto_rd_en,
    output logic              rd_start,
    output logic              trig_forced,
    output logic [2:0]        acq_state,
    output logic [15:0]       frame_cnt,
    output logic              busy
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REARM     = 3'd1,
        S_PRETRIG   = 3'd2,
        S_WAIT_TRIG = 3'd3,
        S_POSTTRIG  = 3'd4,
        S_READOUT   = 3'd5
    } state_t;

    state_t            state;

    // Control inputs are registered once; the FSM acts on these copies.
    logic              run_s, run_d;
    logic              trig_s, trig_d;
    logic              force_s, ws_s, rd_s;

    logic              single_l;
    logic [ADDR_W-1:0] pre_len_l, pre_cnt;
    logic [TO_W-1:0]   to_len_l, to_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic run_rise, trig_evt, timeout_hit, pre_done;
    logic in_frame, frame_end, enter_rearm, go_idle;

    assign run_rise    = run_s & ~run_d;
    assign trig_evt    = trig_s & ~trig_d;
    assign timeout_hit = auto_mode && (to_cnt == to_len_l);
    // Count includes the current strobe so a length of N spans N cycles;
    // a zero length matches immediately and PRETRIG lasts one cycle.
    assign pre_done    = (pre_cnt == pre_len_l) ||
                         (sync_en && ((pre_cnt + 1'b1) == pre_len_l));
    assign in_frame    = (state == S_REARM) || (state == S_PRETRIG) ||
                         (state == S_WAIT_TRIG) || (state == S_POSTTRIG);
    assign frame_end   = (state == S_READOUT) && rd_s;
    assign enter_rearm = ((state == S_IDLE) && run_rise) ||
                         (frame_end && !single_l && run_s);
    assign go_idle     = (in_frame && !run_s) ||
                         (frame_end && (single_l || !run_s));

    assign acq_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            run_s          <= 1'b0;
            run_d          <= 1'b0;
            // Reset high so a trigger already asserted at reset is not an edge.
            trig_s         <= 1'b1;
            trig_d         <= 1'b1;
            force_s        <= 1'b0;
            ws_s           <= 1'b0;
            rd_s           <= 1'b0;
            single_l       <= 1'b0;
            pre_len_l      <= '0;
            pre_cnt        <= '0;
            to_len_l       <= '0;
            to_cnt         <= '0;
            hold_cnt       <= '0;
            addr_gen_rst_n <= 1'b0;
            wr_en          <= 1'b0;
            auto_rd_en     <= 1'b0;
            rd_start       <= 1'b0;
            trig_forced    <= 1'b0;
            frame_cnt      <= '0;
            busy           <= 1'b0;
        end else begin
            run_s    <= run;
            run_d    <= run_s;
            trig_s   <= trig_in;
            trig_d   <= trig_s;
            force_s  <= force_trig;
            ws_s     <= write_stop;
            rd_s     <= rd_done;
            rd_start <= 1'b0;

            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            if (go_idle) begin
                state          <= S_IDLE;
                addr_gen_rst_n <= 1'b0;
                wr_en          <= 1'b0;
                auto_rd_en     <= 1'b0;
                busy           <= 1'b0;
            end else if (enter_rearm) begin
                state          <= S_REARM;
                busy           <= 1'b1;
                addr_gen_rst_n <= 1'b0;
                wr_en          <= 1'b0;
                auto_rd_en     <= 1'b0;
                hold_cnt       <= HOLD_W'(RST_HOLD - 1);
                single_l       <= single;
                pre_len_l      <= pretrig_len;
                to_len_l       <= timeout_len;
                pre_cnt        <= '0;
                to_cnt         <= '0;
                trig_forced    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                    end
                    S_REARM: begin
                        if (hold_cnt == '0) begin
                            state          <= S_PRETRIG;
                            addr_gen_rst_n <= 1'b1;
                            wr_en          <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                    S_PRETRIG: begin
                        if (sync_en) begin
                            pre_cnt <= pre_cnt + 1'b1;
                        end
                        if (pre_done) begin
                            state      <= S_WAIT_TRIG;
                            auto_rd_en <= 1'b1;
                        end
                    end
                    S_WAIT_TRIG: begin
                        to_cnt <= to_cnt + 1'b1;
                        if (trig_evt || force_s || timeout_hit) begin
                            state       <= S_POSTTRIG;
                            auto_rd_en  <= 1'b0;
                            // A real trigger edge wins over a coincident forced one.
                            trig_forced <= !trig_evt;
                        end
                    end
                    S_POSTTRIG: begin
                        if (ws_s) begin
                            state    <= S_READOUT;
                            wr_en    <= 1'b0;
                            rd_start <= 1'b1;
                        end
                    end
                    S_READOUT: begin
                    end
                    default: begin
                        state          <= S_IDLE;
                        addr_gen_rst_n <= 1'b0;
                        wr_en          <= 1'b0;
                        auto_rd_en     <= 1'b0;
                        busy           <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acq_seq_ctrl.sv
// tb_acq_seq_ctrl
// Self-checking bench for acq_seq_ctrl. Expected phase lengths, trigger
// sources and frame counts come from plain arithmetic on the stimulus.

module tb_acq_seq_ctrl;

    localparam int ADDR_W   = 28;
    localparam int TO_W     = 32;
    localparam int RST_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              run, single, auto_mode, force_trig, trig_in, sync_en;
    logic [ADDR_W-1:0] pretrig_len;
    logic [TO_W-1:0]   timeout_len;
    logic              write_stop, rd_done;
    logic              addr_gen_rst_n, wr_en, auto_rd_en, rd_start, trig_forced, busy;
    logic [2:0]        acq_state;
    logic [15:0]       frame_cnt;

    int n_pass = 0;
    int n_total = 0;
    int exp_frames = 0;
    bit sync_pat [64];

    always #5 clk = ~clk;

    acq_seq_ctrl #(.ADDR_W(ADDR_W), .TO_W(TO_W), .RST_HOLD(RST_HOLD)) dut (
        .clk(clk), .rst(rst), .run(run), .single(single), .auto_mode(auto_mode),
        .force_trig(force_trig), .trig_in(trig_in), .sync_en(sync_en),
        .pretrig_len(pretrig_len), .timeout_len(timeout_len),
        .write_stop(write_stop), .rd_done(rd_done),
        .addr_gen_rst_n(addr_gen_rst_n), .wr_en(wr_en), .auto_rd_en(auto_rd_en),
        .rd_start(rd_start), .trig_forced(trig_forced), .acq_state(acq_state),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input logic [2:0] code, input int budget, output bit ok);
        int i;
        i = 0;
        while (i < budget && acq_state !== code) begin
            step(1);
            i++;
        end
        ok = (acq_state === code);
    endtask

    task automatic restart_run();
        run = 1'b0;
        step(3);
        run = 1'b1;
    endtask

    // Cycles spent in pre-trigger fill: until the strobes seen (current one
    // included) reach the length; a zero length still takes one cycle.
    function automatic int pretrig_cycles(input int len);
        int sum;
        if (len == 0) return 1;
        sum = 0;
        for (int k = 0; k < 64; k++) begin
            if (sync_pat[k]) sum++;
            if (sum == len) return k + 1;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b0; run = 1'b0; single = 1'b0; auto_mode = 1'b0; force_trig = 1'b0;
        trig_in = 1'b0; sync_en = 1'b0; pretrig_len = '0; timeout_len = '0;
        write_stop = 1'b0; rd_done = 1'b0;
        step(2);
        n_total++;
        if ({addr_gen_rst_n, wr_en, auto_rd_en, rd_start, trig_forced, busy, acq_state, frame_cnt} !== 25'd0)
            $display("FAIL reset_values: got %b required all zero",
                     {addr_gen_rst_n, wr_en, auto_rd_en, rd_start, trig_forced, busy, acq_state, frame_cnt});
        else n_pass++;
        rst = 1'b1;
        step(3);
        n_total++;
        if (acq_state !== 3'd0 || busy !== 1'b0)
            $display("FAIL idle_after_reset: state %0d busy %b required 0 0", acq_state, busy);
        else n_pass++;
    endtask

    task automatic test_single_shot();
        int cnt;
        bit bad;
        single = 1'b1; pretrig_len = 8; sync_en = 1'b1;
        run = 1'b1;
        step(1);
        n_total++;
        if (acq_state !== 3'd0) $display("FAIL run_latency_early: state %0d required 0", acq_state);
        else n_pass++;
        step(1);
        n_total++;
        if (acq_state !== 3'd1) $display("FAIL run_latency: state %0d required 1", acq_state);
        else n_pass++;
        cnt = 0; bad = 0;
        while (acq_state === 3'd1 && cnt < 50) begin
            if (addr_gen_rst_n !== 1'b0) bad = 1;
            step(1);
            cnt++;
        end
        n_total++;
        if (cnt != RST_HOLD || bad || addr_gen_rst_n !== 1'b1 || acq_state !== 3'd2)
            $display("FAIL rearm_hold: cycles %0d rst_n %b state %0d required %0d 1 2",
                     cnt, addr_gen_rst_n, acq_state, RST_HOLD);
        else n_pass++;
        cnt = 0;
        while (acq_state === 3'd2 && cnt < 64) begin
            step(1);
            cnt++;
        end
        n_total++;
        if (cnt != 8 || auto_rd_en !== 1'b1 || acq_state !== 3'd3)
            $display("FAIL pretrig_len8: cycles %0d auto_rd_en %b required 8 1", cnt, auto_rd_en);
        else n_pass++;
        trig_in = 1'b1;
        step(1);
        n_total++;
        if (auto_rd_en !== 1'b1) $display("FAIL trig_latency_early: auto_rd_en %b required 1", auto_rd_en);
        else n_pass++;
        step(1);
        n_total++;
        if (auto_rd_en !== 1'b0 || acq_state !== 3'd4 || trig_forced !== 1'b0)
            $display("FAIL trig_latency: auto_rd_en %b state %0d forced %b required 0 4 0",
                     auto_rd_en, acq_state, trig_forced);
        else n_pass++;
        write_stop = 1'b1;
        step(2);
        n_total++;
        if (rd_start !== 1'b1 || wr_en !== 1'b0 || acq_state !== 3'd5)
            $display("FAIL rd_start_pulse: rd_start %b wr_en %b state %0d required 1 0 5",
                     rd_start, wr_en, acq_state);
        else n_pass++;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (rd_start === 1'b1) cnt++;
        end
        n_total++;
        if (cnt != 0) $display("FAIL rd_start_width: extra pulses %0d required 0", cnt);
        else n_pass++;
        write_stop = 1'b0;
        rd_done = 1'b1;
        step(1);
        rd_done = 1'b0;
        step(1);
        exp_frames++;
        n_total++;
        if (acq_state !== 3'd0 || frame_cnt !== 16'(exp_frames) || busy !== 1'b0)
            $display("FAIL single_done: state %0d frames %0d required 0 %0d", acq_state, frame_cnt, exp_frames);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (acq_state !== 3'd0) bad = 1;
        end
        n_total++;
        if (bad) $display("FAIL single_no_rearm: state %0d required 0", acq_state);
        else n_pass++;
        trig_in = 1'b0;
    endtask

    task automatic test_continuous();
        int len, exp_len, cnt, d;
        bit ok, use_force, bad;
        single = 1'b0; auto_mode = 1'b0;
        len = $urandom_range(0, 12);
        pretrig_len = ADDR_W'(len);
        restart_run();
        for (int f = 0; f < 3; f++) begin
            wait_state(3'd2, 30, ok);
            n_total++;
            if (!ok) $display("FAIL cont_reach_pretrig f%0d: state %0d required 2", f, acq_state);
            else n_pass++;
            for (int i = 0; i < 64; i++) sync_pat[i] = (i >= 30) ? 1'b1 : ($urandom_range(0, 1) == 1);
            exp_len = pretrig_cycles(len);
            cnt = 0;
            while (acq_state === 3'd2 && cnt < 64) begin
                sync_en = sync_pat[cnt];
                step(1);
                cnt++;
            end
            sync_en = 1'b1;
            n_total++;
            if (cnt != exp_len || acq_state !== 3'd3)
                $display("FAIL cont_pretrig f%0d len %0d: cycles %0d required %0d", f, len, cnt, exp_len);
            else n_pass++;
            d = $urandom_range(0, 5);
            step(d);
            use_force = ($urandom_range(0, 1) == 1);
            if (use_force) force_trig = 1'b1;
            else trig_in = 1'b1;
            step(1);
            force_trig = 1'b0; trig_in = 1'b0;
            step(1);
            n_total++;
            if (acq_state !== 3'd4 || auto_rd_en !== 1'b0)
                $display("FAIL cont_trigger f%0d: state %0d required 4", f, acq_state);
            else n_pass++;
            d = $urandom_range(0, 3);
            bad = 0;
            for (int i = 0; i < d; i++) begin
                step(1);
                if (rd_start !== 1'b0 || acq_state !== 3'd4) bad = 1;
            end
            write_stop = 1'b1;
            step(1);
            write_stop = 1'b0;
            step(1);
            n_total++;
            if (bad || rd_start !== 1'b1 || trig_forced !== use_force)
                $display("FAIL cont_handoff f%0d: rd_start %b forced %b required 1 %b",
                         f, rd_start, trig_forced, use_force);
            else n_pass++;
            if (f == 2) begin
                run = 1'b0;
                step(3);
                n_total++;
                if (acq_state !== 3'd5) $display("FAIL readout_holds: state %0d required 5", acq_state);
                else n_pass++;
            end
            len = $urandom_range(0, 12);
            pretrig_len = ADDR_W'(len);
            rd_done = 1'b1;
            step(1);
            rd_done = 1'b0;
            step(1);
            exp_frames++;
            n_total++;
            if (frame_cnt !== 16'(exp_frames) || acq_state !== ((f < 2) ? 3'd1 : 3'd0))
                $display("FAIL cont_frame_end f%0d: frames %0d state %0d required %0d %0d",
                         f, frame_cnt, acq_state, exp_frames, (f < 2) ? 1 : 0);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int t, cnt;
        bit ok;
        for (int r = 0; r < 2; r++) begin
            t = (r == 0) ? 100 : $urandom_range(0, 40);
            auto_mode = 1'b1; single = 1'b1; pretrig_len = '0; timeout_len = TO_W'(t);
            restart_run();
            wait_state(3'd3, 40, ok);
            n_total++;
            if (!ok) $display("FAIL to_reach_wait T%0d: state %0d required 3", t, acq_state);
            else n_pass++;
            cnt = 0;
            while (acq_state === 3'd3 && cnt < 300) begin
                step(1);
                cnt++;
            end
            n_total++;
            if (cnt != t + 1 || auto_rd_en !== 1'b0)
                $display("FAIL timeout T%0d: cycles %0d required %0d", t, cnt, t + 1);
            else n_pass++;
            write_stop = 1'b1;
            step(1);
            write_stop = 1'b0;
            step(1);
            n_total++;
            if (rd_start !== 1'b1 || trig_forced !== 1'b1)
                $display("FAIL timeout_forced T%0d: rd_start %b forced %b required 1 1", t, rd_start, trig_forced);
            else n_pass++;
            rd_done = 1'b1;
            step(1);
            rd_done = 1'b0;
            step(1);
            exp_frames++;
            n_total++;
            if (acq_state !== 3'd0 || frame_cnt !== 16'(exp_frames))
                $display("FAIL timeout_done T%0d: state %0d frames %0d required 0 %0d",
                         t, acq_state, frame_cnt, exp_frames);
            else n_pass++;
        end
        auto_mode = 1'b0;
    endtask

    task automatic test_trig_filter();
        int cnt;
        bit ok, bad;
        single = 1'b1; pretrig_len = 10; sync_en = 1'b1;
        restart_run();
        wait_state(3'd2, 30, ok);
        cnt = 0;
        while (acq_state === 3'd2 && cnt < 64) begin
            trig_in = (cnt == 3);
            step(1);
            cnt++;
        end
        trig_in = 1'b0;
        n_total++;
        if (!ok || cnt != 10) $display("FAIL pretrig_trig_ignored: cycles %0d required 10", cnt);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (acq_state !== 3'd3) bad = 1;
        end
        n_total++;
        if (bad) $display("FAIL no_late_trigger: state %0d required 3", acq_state);
        else n_pass++;
        trig_in = 1'b1; force_trig = 1'b1;
        step(1);
        trig_in = 1'b0; force_trig = 1'b0;
        step(1);
        write_stop = 1'b1;
        step(1);
        write_stop = 1'b0;
        step(1);
        n_total++;
        if (rd_start !== 1'b1 || trig_forced !== 1'b0)
            $display("FAIL simul_trigger: rd_start %b forced %b required 1 0", rd_start, trig_forced);
        else n_pass++;
        rd_done = 1'b1;
        step(1);
        rd_done = 1'b0;
        step(1);
        exp_frames++;
        n_total++;
        if (frame_cnt !== 16'(exp_frames) || acq_state !== 3'd0)
            $display("FAIL simul_done: frames %0d required %0d", frame_cnt, exp_frames);
        else n_pass++;
    endtask

    task automatic test_abort();
        int pulses;
        bit ok;
        single = 1'b0; pretrig_len = 2; sync_en = 1'b1;
        restart_run();
        wait_state(3'd3, 40, ok);
        n_total++;
        if (!ok) $display("FAIL abort_reach_wait: state %0d required 3", acq_state);
        else n_pass++;
        run = 1'b0;
        step(1);
        n_total++;
        if (acq_state !== 3'd3) $display("FAIL abort_early: state %0d required 3", acq_state);
        else n_pass++;
        step(1);
        n_total++;
        if (acq_state !== 3'd0 || busy !== 1'b0 || wr_en !== 1'b0 || addr_gen_rst_n !== 1'b0)
            $display("FAIL abort_idle: state %0d busy %b wr_en %b required 0 0 0", acq_state, busy, wr_en);
        else n_pass++;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (rd_start === 1'b1) pulses++;
        end
        n_total++;
        if (pulses != 0 || frame_cnt !== 16'(exp_frames))
            $display("FAIL abort_no_count: pulses %0d frames %0d required 0 %0d", pulses, frame_cnt, exp_frames);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        single = 1'b0; pretrig_len = '0;
        restart_run();
        wait_state(3'd3, 40, ok);
        force_trig = 1'b1;
        step(1);
        force_trig = 1'b0;
        step(1);
        n_total++;
        if (!ok || acq_state !== 3'd4) $display("FAIL reach_posttrig: state %0d required 4", acq_state);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if ({addr_gen_rst_n, wr_en, auto_rd_en, rd_start, trig_forced, busy, acq_state, frame_cnt} !== 25'd0)
            $display("FAIL async_reset_mid: got %b required all zero",
                     {addr_gen_rst_n, wr_en, auto_rd_en, rd_start, trig_forced, busy, acq_state, frame_cnt});
        else n_pass++;
        run = 1'b0;
        #2 rst = 1'b1;
        step(2);
        exp_frames = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_shot();
        test_continuous();
        test_timeout();
        test_trig_filter();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
